// File: rtl/ask4_mapper_upsampler_if.sv
// Sample-rate stream between the 4-ASK mapper/upsampler and its neighbours:
// strobe and symbol in, upsampled amplitude, symbol strobe and phase out.
interface ask4_mapper_upsampler_if;
    logic               sam_clk_ena;
    logic [1:0]         sym_in;
    logic signed [17:0] sample_out;
    logic               sym_clk_ena;
    logic [1:0]         phase;

    modport master (
        output sam_clk_ena,
        output sym_in,
        input  sample_out,
        input  sym_clk_ena,
        input  phase
    );

    modport slave (
        input  sam_clk_ena,
        input  sym_in,
        output sample_out,
        output sym_clk_ena,
        output phase
    );
endinterface

// File: rtl/ask4_mapper_upsampler.sv
// 4-ASK symbol mapper with x4 zero-stuffing upsampler, symbol-rate LFSR
// enable and saturating per-level hit counters.
module ask4_mapper_upsampler #(
    parameter bit          GRAY    = 1'b1,
    parameter int unsigned A_LEVEL = 32768,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    ask4_mapper_upsampler_if.slave bus,
    input  logic                  clr_stats,
    output logic [CNT_W-1:0]      cnt_n3,
    output logic [CNT_W-1:0]      cnt_n1,
    output logic [CNT_W-1:0]      cnt_p1,
    output logic [CNT_W-1:0]      cnt_p3
);

    localparam logic signed [17:0] LVL_A  = 18'(A_LEVEL);
    localparam logic signed [17:0] LVL_3A = (LVL_A <<< 1) + LVL_A;

    logic [1:0]         phase_q;
    logic               sym_ena_q;
    logic signed [17:0] sample_q;
    logic               capture;
    logic [1:0]         lvl_idx;
    logic signed [17:0] level;
    logic [CNT_W-1:0]   cnt [4];

    assign capture = bus.sam_clk_ena && (phase_q == 2'd0);

    // lvl_idx orders the levels -3a, -a, +a, +3a; it also selects the counter
    always_comb begin
        lvl_idx = GRAY ? {bus.sym_in[1], bus.sym_in[1] ^ bus.sym_in[0]} : bus.sym_in;
        case (lvl_idx)
            2'd0:    level = -LVL_3A;
            2'd1:    level = -LVL_A;
            2'd2:    level = LVL_A;
            default: level = LVL_3A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= '0;
            sample_q  <= '0;
            sym_ena_q <= 1'b0;
        end else begin
            sym_ena_q <= capture;
            if (bus.sam_clk_ena) begin
                phase_q  <= phase_q + 2'd1;
                sample_q <= capture ? level : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_stats) begin
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (capture && (cnt[lvl_idx] != '1)) begin
            cnt[lvl_idx] <= cnt[lvl_idx] + CNT_W'(1);
        end
    end

    assign bus.phase       = phase_q;
    assign bus.sample_out  = sample_q;
    assign bus.sym_clk_ena = sym_ena_q;
    assign cnt_n3 = cnt[0];
    assign cnt_n1 = cnt[1];
    assign cnt_p1 = cnt[2];
    assign cnt_p3 = cnt[3];

endmodule

// File: tb/tb_ask4_mapper_upsampler.sv
// Bench for ask4_mapper_upsampler: a Gray/16-bit and a binary/4-bit instance
// share stimulus and are compared every clk against a strobe-counting model.
module tb_ask4_mapper_upsampler;

    localparam int A = 32768;

    logic clk = 1'b0;
    logic reset;
    logic clr_stats;

    ask4_mapper_upsampler_if if_g ();
    ask4_mapper_upsampler_if if_b ();

    logic [15:0] g_n3, g_n1, g_p1, g_p3;
    logic [3:0]  b_n3, b_n1, b_p1, b_p3;

    ask4_mapper_upsampler #(.GRAY(1'b1), .A_LEVEL(32768), .CNT_W(16)) dut_g (
        .clk(clk), .reset(reset), .bus(if_g), .clr_stats(clr_stats),
        .cnt_n3(g_n3), .cnt_n1(g_n1), .cnt_p1(g_p1), .cnt_p3(g_p3)
    );

    ask4_mapper_upsampler #(.GRAY(1'b0), .A_LEVEL(32768), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b), .clr_stats(clr_stats),
        .cnt_n3(b_n3), .cnt_n1(b_n1), .cnt_p1(b_p1), .cnt_p3(b_p3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Symbol source: 22-bit maximal LFSR advanced by the DUT's symbol strobe
    logic [21:0] lfsr = 22'h2A5F3C;
    bit          lfsr_mode = 1'b0;
    always @(posedge clk) begin
        if (if_g.sym_clk_ena === 1'b1) lfsr <= {lfsr[20:0], lfsr[21] ^ lfsr[20]};
    end

    // Model state: strobes since reset, expected outputs per instance
    int strobes = 0;
    int captures = 0;
    int exp_sample [2];
    int exp_cnt [2][4];
    bit exp_ena = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lvl_index(input logic [1:0] s, input bit gray);
        logic [1:0] order [4];
        order[0] = 2'b00; order[1] = 2'b01; order[2] = 2'b11; order[3] = 2'b10;
        if (!gray) return int'(s);
        for (int i = 0; i < 4; i++) if (order[i] == s) return i;
        return 0;
    endfunction

    task automatic compare_all();
        check("g_sample", longint'($signed(if_g.sample_out)), exp_sample[0]);
        check("b_sample", longint'($signed(if_b.sample_out)), exp_sample[1]);
        check("g_phase", if_g.phase, strobes % 4);
        check("b_phase", if_b.phase, strobes % 4);
        check("g_sym_ena", if_g.sym_clk_ena, exp_ena);
        check("b_sym_ena", if_b.sym_clk_ena, exp_ena);
        check("g_cnt_n3", g_n3, exp_cnt[0][0]);
        check("g_cnt_n1", g_n1, exp_cnt[0][1]);
        check("g_cnt_p1", g_p1, exp_cnt[0][2]);
        check("g_cnt_p3", g_p3, exp_cnt[0][3]);
        check("b_cnt_n3", b_n3, exp_cnt[1][0]);
        check("b_cnt_n1", b_n1, exp_cnt[1][1]);
        check("b_cnt_p1", b_p1, exp_cnt[1][2]);
        check("b_cnt_p3", b_p3, exp_cnt[1][3]);
    endtask

    task automatic step(input bit ena, input logic [1:0] sym, input bit clr, input bit rst);
        logic [1:0] s;
        int idx;
        int cmax;
        s = lfsr_mode ? lfsr[1:0] : sym;
        reset = rst;
        clr_stats = clr;
        if_g.sam_clk_ena = ena;
        if_b.sam_clk_ena = ena;
        if_g.sym_in = s;
        if_b.sym_in = s;
        @(posedge clk);
        if (rst) begin
            strobes = 0;
            exp_ena = 1'b0;
            for (int k = 0; k < 2; k++) begin
                exp_sample[k] = 0;
                for (int j = 0; j < 4; j++) exp_cnt[k][j] = 0;
            end
        end else begin
            exp_ena = 1'b0;
            for (int k = 0; k < 2; k++) begin
                cmax = (k == 0) ? 65535 : 15;
                if (clr) for (int j = 0; j < 4; j++) exp_cnt[k][j] = 0;
                if (ena) begin
                    if (strobes % 4 == 0) begin
                        idx = lvl_index(s, k == 0);
                        exp_sample[k] = (2 * idx - 3) * A;
                        exp_ena = 1'b1;
                        if (!clr && exp_cnt[k][idx] < cmax) exp_cnt[k][idx]++;
                        if (k == 0) captures++;
                    end else begin
                        exp_sample[k] = 0;
                    end
                end
            end
            if (ena) strobes++;
        end
        #1;
        compare_all();
    endtask

    int pulses;
    int sum;
    logic [1:0] map_seq [4];

    initial begin
        // reset held 3 clks with the strobe toggling
        for (int i = 0; i < 3; i++) step((i % 2) == 1, 2'($urandom), 1'b0, 1'b1);

        // release with sym 10, strobe every 4th clk
        for (int i = 0; i < 16; i++) begin
            step((i % 4) == 0, 2'b10, 1'b0, 1'b0);
            if (i == 0) begin
                check("first_capture_gray", longint'($signed(if_g.sample_out)), 98304);
                check("first_capture_bin", longint'($signed(if_b.sample_out)), 32768);
            end
        end

        // full Gray map, strobe every clk
        step(1'b0, 2'b00, 1'b0, 1'b1);
        map_seq[0] = 2'b00; map_seq[1] = 2'b01; map_seq[2] = 2'b11; map_seq[3] = 2'b10;
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < 4; j++) step(1'b1, map_seq[s], 1'b0, 1'b0);
        check("map_cnt_n3", g_n3, 1);
        check("map_cnt_n1", g_n1, 1);
        check("map_cnt_p1", g_p1, 1);
        check("map_cnt_p3", g_p3, 1);

        // cadence: every 4th clk for 64 clks, then every clk for 32 clks
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            step((i % 4) == 0, 2'($urandom), 1'b0, 1'b0);
            if (if_g.sym_clk_ena) pulses++;
        end
        check("cadence_slow_pulses", pulses, 4);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 2'($urandom), 1'b0, 1'b0);
            if (if_g.sym_clk_ena) pulses++;
        end
        check("cadence_fast_pulses", pulses, 8);

        // saturation of the 4-bit counters, then clear on a capture edge
        step(1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 80; i++) step(1'b1, 2'b00, 1'b0, 1'b0);
        check("sat_b_n3", b_n3, 15);
        check("sat_g_n3", g_n3, 20);
        step(1'b1, 2'b00, 1'b1, 1'b0);
        check("clr_on_capture", b_n3, 0);
        check("clr_sample_kept", longint'($signed(if_b.sample_out)), -98304);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        check("after_clr_count", b_n3, 1);

        // random strobe/symbol/clear traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) != 0, 2'($urandom), $urandom_range(0, 15) == 0, 1'b0);

        // reset while phase is 2
        for (int i = 0; i < 8 && (strobes % 4) != 2; i++) step(1'b1, 2'($urandom), 1'b0, 1'b0);
        check("mid_reset_pre_phase", if_g.phase, 2);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        check("mid_reset_phase", if_g.phase, 0);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        check("mid_reset_capture", longint'($signed(if_g.sample_out)), 32768);
        check("mid_reset_sym_ena", if_g.sym_clk_ena, 1);
        step(1'b0, 2'b11, 1'b0, 1'b0);
        check("mid_reset_sym_ena_off", if_g.sym_clk_ena, 0);

        // LFSR-driven run of 4096 symbols
        step(1'b0, 2'b00, 1'b0, 1'b1);
        captures = 0;
        lfsr_mode = 1'b1;
        for (int i = 0; i < 30000 && captures < 4096; i++) begin
            step($urandom_range(0, 3) != 0, 2'b00, 1'b0, 1'b0);
            if (if_g.sample_out != 0)
                check("lfsr_level_set", longint'($signed(if_g.sample_out) == -98304 || $signed(if_g.sample_out) == -32768 ||
                      $signed(if_g.sample_out) == 32768 || $signed(if_g.sample_out) == 98304), 1);
        end
        lfsr_mode = 1'b0;
        check("lfsr_captures", captures, 4096);
        sum = int'(g_n3) + int'(g_n1) + int'(g_p1) + int'(g_p3);
        check("lfsr_cnt_sum", sum, 4096);
        check("lfsr_n3_uniform", longint'(g_n3 >= 896 && g_n3 <= 1152), 1);
        check("lfsr_n1_uniform", longint'(g_n1 >= 896 && g_n1 <= 1152), 1);
        check("lfsr_p1_uniform", longint'(g_p1 >= 896 && g_p1 <= 1152), 1);
        check("lfsr_p3_uniform", longint'(g_p3 >= 896 && g_p3 <= 1152), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
